// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD
// converter.
//   state_t    : converter FSM states (IDLE / SHIFT / DONE)
//   BIN_W      : binary operand width
//   BCD_DIGITS : BCD digits held internally (fifth digit flags overflow)
//   OUT_DIGITS : BCD digits presented on the output
//   ITER       : shift iterations per conversion
//   magnitude(): absolute value of an operand, two's complement aware
package bin2bcd_pkg;

    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;
    localparam int OUT_DIGITS = 4;
    localparam int ITER       = 16;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int OUT_W      = 4 * OUT_DIGITS;
    localparam int SR_W       = BIN_W + BCD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Two's complement negate when requested. 16'h8000 negates to itself,
    // which read as unsigned is exactly 32768.
    function automatic logic [BIN_W-1:0] magnitude(input logic [BIN_W-1:0] v,
                                                   input logic             is_signed);
        logic [BIN_W-1:0] r;
        r = v;
        if (is_signed && v[BIN_W-1])
            r = ~v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between the binary producer and the
// converter.
//   start    : conversion request (master -> slave)
//   value    : binary operand (master -> slave)
//   busy     : conversion in flight (slave -> master)
//   done     : one-cycle result-valid pulse (slave -> master)
//   bcd      : four packed BCD digits, thousands in the top nibble
//   overflow : result has a non-zero fifth digit
//   neg      : converted operand was negative
import bin2bcd_pkg::*;

interface bin2bcd_seq_if;
    logic             start;
    logic [BIN_W-1:0] value;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] bcd;
    logic             overflow;
    logic             neg;

    modport master (output start, value,
                    input  busy, done, bcd, overflow, neg);
    modport slave  (input  start, value,
                    output busy, done, bcd, overflow, neg);
endinterface

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: one correction cell of the shift-and-add-3 converter.
//   din  : BCD nibble before the next shift
//   dout : din + 3 when din >= 5, otherwise din, so the following left
//          shift carries correctly into the next decimal digit
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 16-bit binary to packed BCD converter, one bit per cycle.
// A conversion takes 17 cycles from the accepting edge to the done pulse;
// results are registered and held until the next done.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any conversion silently
//   bus   : bin2bcd_seq_if.slave (start/value in, busy/done/bcd/overflow/neg out)
// Parameter AUTO = 1 makes the block self-start whenever idle and the operand
// differs from the last converted one (start is ignored).
// Build macro BIN2BCD_SIGNED_EN: treat value as two's complement, convert its
// magnitude and report the sign on neg. Without it value is unsigned and neg
// is tied low.
import bin2bcd_pkg::*;

module bin2bcd_seq #(
    parameter bit AUTO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

`ifdef BIN2BCD_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    state_t           state;
    logic [SR_W-1:0]  sr;        // {BCD field, binary field}
    logic [SR_W-1:0]  adj;       // sr with every BCD nibble corrected
    logic [3:0]       cnt;
    logic [BIN_W-1:0] last_val;
    logic             last_vld;  // cleared by reset so AUTO converts at once
    logic             busy_q;
    logic             done_q;
    logic [OUT_W-1:0] bcd_q;
    logic             ovf_q;
    logic             go;

    // The binary field passes through untouched; each BCD nibble gets its
    // own add-3 cell.
    assign adj[BIN_W-1:0] = sr[BIN_W-1:0];

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_dig
        bcd_add3_digit u_add3 (
            .din  (sr [BIN_W + 4*d +: 4]),
            .dout (adj[BIN_W + 4*d +: 4])
        );
    end

    // Only evaluated in IDLE. In AUTO mode the operand comparison replaces
    // the external request.
    assign go = AUTO ? (!last_vld || (bus.value != last_val)) : bus.start;

`ifdef BIN2BCD_SIGNED_EN
    logic sign_q;
    logic neg_q;
    assign bus.neg = neg_q;
`else
    assign bus.neg = 1'b0;
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sr       <= '0;
            cnt      <= '0;
            last_val <= '0;
            last_vld <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q   <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        sr       <= {{BCD_W{1'b0}}, magnitude(bus.value, SIGNED_EN)};
                        last_val <= bus.value;
                        last_vld <= 1'b1;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
                        sign_q   <= bus.value[BIN_W-1];
`endif
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Correct then shift; the top bit can never be set for
                    // a 16-bit operand, so the full-width shift loses nothing.
                    sr  <= adj << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(ITER - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    bcd_q  <= sr[BIN_W +: OUT_W];
                    ovf_q  <= |sr[BIN_W + OUT_W +: 4];
`ifdef BIN2BCD_SIGNED_EN
                    neg_q  <= sign_q;
`endif
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: drives one AUTO=0 and one AUTO=1 converter side by side.
// Each instance has an arithmetic reference model (divide/modulo decimal
// digits, a countdown for the 17-cycle latency) compared on every falling
// edge, plus directed conversions with literal expected values.
`timescale 1ns/1ps

module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s [2];
    logic [15:0] value_s [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] bcd_w   [2];
    logic        ovf_w   [2];
    logic        neg_w   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Expected {neg, overflow, bcd} for an operand, straight from decimal arithmetic.
    function automatic logic [17:0] ref_conv(input logic [15:0] v);
        int   m;
        int   d;
        logic n;
`ifdef BIN2BCD_SIGNED_EN
        m = int'($signed(v));
        n = (m < 0);
        if (n) m = -m;
`else
        m = int'(v);
        n = 1'b0;
`endif
        d = m % 10000;
        return {n, (m >= 10000),
                4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        bin2bcd_seq_if bif ();

        assign bif.start = start_s[g];
        assign bif.value = value_s[g];
        assign busy_w[g] = bif.busy;
        assign done_w[g] = bif.done;
        assign bcd_w[g]  = bif.bcd;
        assign ovf_w[g]  = bif.overflow;
        assign neg_w[g]  = bif.neg;

        bin2bcd_seq #(.AUTO(g == 1)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bif)
        );

        // Reference: rem counts edges left until results appear.
        int          rem;
        logic [15:0] pend;
        logic [15:0] m_last;
        logic        m_lvld;
        logic        m_done;
        logic [17:0] m_res;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem    <= 0;
                pend   <= '0;
                m_last <= '0;
                m_lvld <= 1'b0;
                m_done <= 1'b0;
                m_res  <= '0;
            end else begin
                m_done <= 1'b0;
                if (rem == 0) begin
                    if ((g == 1) ? (!m_lvld || value_s[g] != m_last) : start_s[g]) begin
                        rem    <= 17;
                        pend   <= value_s[g];
                        m_last <= value_s[g];
                        m_lvld <= 1'b1;
                    end
                end else begin
                    rem <= rem - 1;
                    if (rem == 1) begin
                        m_done <= 1'b1;
                        m_res  <= ref_conv(pend);
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                n_tests++;
                if ({busy_w[g], done_w[g], neg_w[g], ovf_w[g], bcd_w[g]} !==
                    {(rem != 0), m_done, m_res}) begin
                    n_fail++;
                    $display("FAIL inst%0d_cycle t=%0t got busy=%b done=%b neg=%b ovf=%b bcd=%h want busy=%b done=%b neg=%b ovf=%b bcd=%h",
                             g, $time, busy_w[g], done_w[g], neg_w[g], ovf_w[g], bcd_w[g],
                             (rem != 0), m_done, m_res[17], m_res[16], m_res[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // Waits (bounded) for done on instance g; reports edges waited and busy samples.
    task automatic wait_done(input int g, output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy_w[g] ? 1 : 0;
        while (!done_w[g] && lat < 40) begin
            tick();
            lat++;
            if (busy_w[g]) bcnt++;
        end
    endtask

    task automatic convert(input logic [15:0] v, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input logic exp_neg);
        int lat, bc;
        value_s[0] = v;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        wait_done(0, lat, bc);
        chk($sformatf("latency_%h", v), lat, 17);
        chk($sformatf("busy_len_%h", v), bc, 17);
        chk($sformatf("bcd_%h", v), bcd_w[0], exp_bcd);
        chk($sformatf("ovf_%h", v), ovf_w[0], exp_ovf);
        chk($sformatf("neg_%h", v), neg_w[0], exp_neg);
    endtask

    initial begin
        int lat, bc, nd;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        value_s[0] = '0;   value_s[1] = '0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_busy%0d", g), busy_w[g], 0);
            chk($sformatf("rst_done%0d", g), done_w[g], 0);
            chk($sformatf("rst_bcd%0d", g),  bcd_w[g], 0);
            chk($sformatf("rst_ovf%0d", g),  ovf_w[g], 0);
            chk($sformatf("rst_neg%0d", g),  neg_w[g], 0);
        end
        rst_n = 1'b1;
        // AUTO instance self-starts with value 0 right after reset.
        tick();
        chk("auto_first_busy", busy_w[1], 1);

        convert(16'h1234, 16'h4660, 1'b0, 1'b0);
        convert(16'd9999, 16'h9999, 1'b0, 1'b0);
        convert(16'd10000, 16'h0000, 1'b1, 1'b0);
`ifdef BIN2BCD_SIGNED_EN
        convert(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        convert(16'h8000, 16'h2768, 1'b1, 1'b1);
`else
        convert(16'hFFFF, 16'h5535, 1'b1, 1'b0);
`endif

        // Requests while busy are dropped.
        value_s[0] = 16'd100;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        for (int i = 1; i < 12; i++) begin
            start_s[0] = (i == 2 || i == 9);
            value_s[0] = 16'd555 + 16'(i);
            tick();
        end
        start_s[0] = 1'b0;
        wait_done(0, lat, bc);
        chk("ignored_lat", lat, 6);
        chk("ignored_bcd", bcd_w[0], 16'h0100);

        // Start during the done cycle is accepted.
        start_s[0] = 1'b1;
        value_s[0] = 16'd88;
        tick();
        start_s[0] = 1'b0;
        wait_done(0, lat, bc);
        chk("b2b_lat", lat, 17);
        chk("b2b_bcd", bcd_w[0], 16'h0088);

        // Reset mid-conversion.
        value_s[0] = 16'd1234;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_w[0], 0);
        chk("midrst_done", done_w[0], 0);
        chk("midrst_bcd",  bcd_w[0], 0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin tick(); if (done_w[0]) nd++; end
        chk("midrst_no_done", nd, 0);
        convert(16'd321, 16'h0321, 1'b0, 1'b0);

        // Randomised traffic on both instances, checked by the models.
        for (int i = 0; i < 900; i++) begin
            value_s[0] = 16'($urandom);
            start_s[0] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) value_s[1] = 16'($urandom);
            tick();
        end
        start_s[0] = 1'b0;

        // AUTO: stable operand gives no new done, a change gives exactly one.
        repeat (25) tick();
        value_s[1] = 16'd42;
        wait_done(1, lat, bc);
        chk("auto42_lat", lat, 18);
        chk("auto42_bcd", bcd_w[1], 16'h0042);
        nd = 0;
        repeat (30) begin tick(); if (done_w[1]) nd++; end
        chk("auto_hold_no_done", nd, 0);
        value_s[1] = 16'd43;
        nd = 0;
        repeat (30) begin tick(); if (done_w[1]) nd++; end
        chk("auto43_one_done", nd, 1);
        chk("auto43_bcd", bcd_w[1], 16'h0043);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
